// File: rtl/snitch_ro_cache_cfg_ctrl.sv
// snitch_ro_cache_cfg_ctrl
// Runtime configuration sequencer for the read-only cache. It accepts
// WRITE_RULE / SET_ENABLE / FLUSH commands from a register-file-side port and
// drives the cache enable, flush handshake and address-rule inputs. Before it
// changes rules, disables the cache or flushes it, the block drains every
// in-flight cached read. It counts those reads by snooping the AR and R-last
// handshakes on the demux Cache port.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake (ready only in Idle)
//   cmd_op_i                      0 WRITE_RULE, 1 SET_ENABLE, 2 FLUSH, 3 reserved
//   cmd_idx_i, cmd_start_i,
//   cmd_end_i, cmd_en_i           command operands
//   busy_o, done_o                command in progress / one-cycle completion pulse
//   err_o, err_clr_i              sticky error flag and its clear
//   cache_ar_hs_i,
//   cache_r_last_hs_i             snooped Cache-port handshakes
//   enable_o, flush_valid_o,
//   flush_ready_i                 cache enable and flush handshake
//   start_addr_o, end_addr_o      per-rule cacheable region
//   outstanding_o                 current outstanding cached-read count
module snitch_ro_cache_cfg_ctrl #(
  parameter int unsigned AxiAddrWidth = 0,
  parameter int unsigned NrAddrRules  = 1,
  parameter int unsigned MaxTrans     = 0,
  parameter logic        EnableRst    = 1'b0,
  // Widths are clamped to 1 so the unconfigured defaults still elaborate.
  localparam int unsigned AddrW = (AxiAddrWidth > 0) ? AxiAddrWidth : 1,
  localparam int unsigned IdxW  = (NrAddrRules > 1) ? $clog2(NrAddrRules) : 1,
  localparam int unsigned CntW  = (MaxTrans > 0) ? $clog2(MaxTrans + 1) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [1:0]                          cmd_op_i,
  input  logic [IdxW-1:0]                     cmd_idx_i,
  input  logic [AddrW-1:0]                    cmd_start_i,
  input  logic [AddrW-1:0]                    cmd_end_i,
  input  logic                                cmd_en_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  input  logic                                err_clr_i,
  input  logic                                cache_ar_hs_i,
  input  logic                                cache_r_last_hs_i,
  output logic                                enable_o,
  output logic                                flush_valid_o,
  input  logic                                flush_ready_i,
  output logic [NrAddrRules-1:0][AddrW-1:0]   start_addr_o,
  output logic [NrAddrRules-1:0][AddrW-1:0]   end_addr_o,
  output logic [CntW-1:0]                     outstanding_o
);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush,
    StApply
  } state_e;

  typedef enum logic [1:0] {
    OpWriteRule = 2'd0,
    OpSetEnable = 2'd1,
    OpFlush     = 2'd2,
    OpRsvd      = 2'd3
  } op_e;

  state_e state_q, state_d;

  // Latched command
  op_e              op_q;
  logic [IdxW-1:0]  idx_q;
  logic [AddrW-1:0] start_cmd_q, end_cmd_q;
  logic             en_cmd_q;
  logic             bad_q;
  logic             en_saved_q;

  // Registered outputs
  logic                              enable_q, enable_d;
  logic                              flush_q, flush_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic [NrAddrRules-1:0][AddrW-1:0] start_q, end_q;
  logic [CntW-1:0]                   cnt_q, cnt_d;

  // Decode of the incoming command
  op_e  cmd_op;
  logic idx_ok;
  logic cmd_bad;
  logic cmd_accept;

  assign cmd_op     = op_e'(cmd_op_i);
  assign idx_ok     = (32'(cmd_idx_i) < NrAddrRules);
  assign cmd_bad    = (cmd_op == OpRsvd) || ((cmd_op == OpWriteRule) && !idx_ok);
  assign cmd_accept = (state_q == StIdle) && cmd_valid_i;

  // --------------------------------------------------------------------------
  // Outstanding-read counter
  // --------------------------------------------------------------------------
  logic cnt_inc, cnt_dec, cnt_err;

  assign cnt_inc = cache_ar_hs_i && !cache_r_last_hs_i;
  assign cnt_dec = cache_r_last_hs_i && !cache_ar_hs_i;

  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (cnt_inc) begin
      if (cnt_q == CntW'(MaxTrans)) cnt_err = 1'b1;
      else                          cnt_d   = cnt_q + 1'b1;
    end else if (cnt_dec) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          case (cmd_op)
            OpWriteRule: state_d = idx_ok ? StDrain : StApply;
            OpSetEnable: state_d = cmd_en_i ? StApply : StDrain;
            OpFlush:     state_d = StDrain;
            default:     state_d = StApply;
          endcase
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = (op_q == OpSetEnable) ? StApply : StFlush;
      end
      StFlush: begin
        if (flush_ready_i) state_d = StApply;
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  logic rule_we;
  logic err_cmd;

  always_comb begin
    enable_d = enable_q;
    flush_d  = flush_q;
    done_d   = (state_d == StApply);
    rule_we  = 1'b0;
    err_cmd  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          err_cmd = cmd_bad;
          // The cache is switched off as soon as a draining command is taken.
          if (state_d == StDrain) enable_d = 1'b0;
        end
      end
      StDrain: begin
        if (state_d == StFlush) flush_d = 1'b1;
      end
      StFlush: begin
        // Valid is only dropped once the handshake completes.
        if (flush_ready_i) flush_d = 1'b0;
      end
      StApply: begin
        if (!bad_q) begin
          case (op_q)
            OpWriteRule: begin
              rule_we  = 1'b1;
              enable_d = en_saved_q;
            end
            OpSetEnable: enable_d = en_cmd_q;
            OpFlush:     enable_d = en_saved_q;
            default:     enable_d = enable_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  // A new error in the same cycle takes priority over the clear.
  always_comb begin
    err_d = err_q;
    if (cnt_err || err_cmd) err_d = 1'b1;
    else if (err_clr_i)     err_d = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q    <= EnableRst;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      op_q        <= OpWriteRule;
      idx_q       <= '0;
      start_cmd_q <= '0;
      end_cmd_q   <= '0;
      en_cmd_q    <= 1'b0;
      bad_q       <= 1'b0;
      en_saved_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      if (cmd_accept) begin
        op_q        <= cmd_op;
        idx_q       <= cmd_idx_i;
        start_cmd_q <= cmd_start_i;
        end_cmd_q   <= cmd_end_i;
        en_cmd_q    <= cmd_en_i;
        bad_q       <= cmd_bad;
        en_saved_q  <= enable_q;
      end
      // bad_q guarantees idx_q is in range here.
      if (rule_we) begin
        start_q[idx_q] <= start_cmd_q;
        end_q[idx_q]   <= end_cmd_q;
      end
    end
  end

  assign cmd_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign enable_o      = enable_q;
  assign flush_valid_o = flush_q;
  assign start_addr_o  = start_q;
  assign end_addr_o    = end_q;
  assign outstanding_o = cnt_q;

endmodule
